scroll_addr: RTL and testbench

- VRAM address / scroll register block (the "loopy" v/t/x/w registers) that sits directly upstream of the background renderer.
- Decodes CPU writes to PPUCTRL, PPUSCROLL and PPUADDR, and reads of PPUSTATUS.
- Applies the renderer's scroll strobes: inc_cx, inc_y, copy_h, and copy_v (driven from the renderer's return00).
- Produces the nametable/attribute fetch address, fine_x, and the 2-bit attribute quadrant (attr_o, fed to the renderer's attr_i).

---
 rtl/ppu_pkg.sv | 26 ++
 rtl/scroll_inc.sv | 39 +++
 rtl/scroll_addr.sv | 148 ++++++++++++++
 tb/tb_scroll_addr.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - PPU register selects, VRAM address constants and loopy v/t field indices
// Shared by the scroll/address block and the background renderer.
package ppu_pkg;

   localparam logic [2:0] REG_PPUCTRL   = 3'd0;
   localparam logic [2:0] REG_PPUMASK   = 3'd1;
   localparam logic [2:0] REG_PPUSTATUS = 3'd2;
   localparam logic [2:0] REG_OAMADDR   = 3'd3;
   localparam logic [2:0] REG_OAMDATA   = 3'd4;
   localparam logic [2:0] REG_PPUSCROLL = 3'd5;
   localparam logic [2:0] REG_PPUADDR   = 3'd6;
   localparam logic [2:0] REG_PPUDATA   = 3'd7;

   localparam logic [13:0] NT_BASE   = 14'h2000;
   localparam logic [9:0]  AT_OFFSET = 10'h3C0;

   localparam int CX_LSB = 0;
   localparam int CX_MSB = 4;
   localparam int CY_LSB = 5;
   localparam int CY_MSB = 9;
   localparam int NT_X   = 10;
   localparam int NT_Y   = 11;
   localparam int FY_LSB = 12;
   localparam int FY_MSB = 14;

endpackage

// File: rtl/scroll_inc.sv
// rtl/scroll_inc.sv - combinational coarse-X and Y incrementers for the loopy v register
// Each output is v with only its own fields advanced, so the caller can merge them freely.
module scroll_inc
   import ppu_pkg::*;
(
   input  logic [14:0] i_v,
   output logic [14:0] o_v_cx,
   output logic [14:0] o_v_y
);

   always_comb begin
      o_v_cx = i_v;
      if (i_v[CX_MSB:CX_LSB] == 5'd31) begin
         o_v_cx[CX_MSB:CX_LSB] = 5'd0;
         o_v_cx[NT_X]          = ~i_v[NT_X];
      end else begin
         o_v_cx[CX_MSB:CX_LSB] = i_v[CX_MSB:CX_LSB] + 5'd1;
      end
   end

   // Row 29 is the last visible tile row; 30/31 are attribute rows and wrap without a nametable flip.
   always_comb begin
      o_v_y = i_v;
      if (i_v[FY_MSB:FY_LSB] != 3'd7) begin
         o_v_y[FY_MSB:FY_LSB] = i_v[FY_MSB:FY_LSB] + 3'd1;
      end else begin
         o_v_y[FY_MSB:FY_LSB] = 3'd0;
         case (i_v[CY_MSB:CY_LSB])
            5'd29: begin
               o_v_y[CY_MSB:CY_LSB] = 5'd0;
               o_v_y[NT_Y]          = ~i_v[NT_Y];
            end
            5'd31:   o_v_y[CY_MSB:CY_LSB] = 5'd0;
            default: o_v_y[CY_MSB:CY_LSB] = i_v[CY_MSB:CY_LSB] + 5'd1;
         endcase
      end
   end

endmodule

// File: rtl/scroll_addr.sv
// rtl/scroll_addr.sv - loopy v/t/x/w scroll registers, VRAM fetch address mux and attribute select
// Option SCROLL_RENDER_GLITCH_EN: PPUDATA access during rendering bumps coarse X and Y together.
module scroll_addr
   import ppu_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        reg_wr,
   input  logic        reg_rd,
   input  logic [2:0]  reg_sel,
   input  logic [7:0]  reg_din,
   input  logic        data_inc,
   input  logic        inc32,
   input  logic        render_en,
   input  logic        inc_cx,
   input  logic        inc_y,
   input  logic        copy_h,
   input  logic        copy_v,
   input  logic        fetch_nt,
   input  logic        fetch_attr,
   input  logic [7:0]  data_i,
   output logic [13:0] vaddr,
   output logic [2:0]  fine_x,
   output logic [2:0]  fine_y,
   output logic [1:0]  attr_o
);

   logic [14:0] r_v, r_t;
   logic [2:0]  r_x;
   logic        r_w;

   logic [14:0] w_v_nxt, w_t_nxt;
   logic [2:0]  w_x_nxt;
   logic        w_w_nxt;
   logic [14:0] w_v_cx, w_v_y;
   logic        w_glitch;
   logic        w_do_cx, w_do_y;

   logic w_wr_ctrl, w_wr_scroll, w_wr_addr, w_rd_status;

   assign w_wr_ctrl   = reg_wr && (reg_sel == REG_PPUCTRL);
   assign w_wr_scroll = reg_wr && (reg_sel == REG_PPUSCROLL);
   assign w_wr_addr   = reg_wr && (reg_sel == REG_PPUADDR);
   assign w_rd_status = reg_rd && (reg_sel == REG_PPUSTATUS);

`ifdef SCROLL_RENDER_GLITCH_EN
   assign w_glitch = data_inc;
`else
   assign w_glitch = 1'b0;
`endif

   assign w_do_cx = inc_cx | w_glitch;
   assign w_do_y  = inc_y  | w_glitch;

   scroll_inc u_inc (
      .i_v    (r_v),
      .o_v_cx (w_v_cx),
      .o_v_y  (w_v_y)
   );

   // Register writes see the old w; a status read clears w afterwards.
   always_comb begin
      w_t_nxt = r_t;
      w_x_nxt = r_x;
      w_w_nxt = r_w;
      if (w_wr_ctrl)
         w_t_nxt[NT_Y:NT_X] = reg_din[1:0];
      if (w_wr_scroll) begin
         if (!r_w) begin
            w_t_nxt[CX_MSB:CX_LSB] = reg_din[7:3];
            w_x_nxt                = reg_din[2:0];
            w_w_nxt                = 1'b1;
         end else begin
            w_t_nxt[FY_MSB:FY_LSB] = reg_din[2:0];
            w_t_nxt[CY_MSB:CY_LSB] = reg_din[7:3];
            w_w_nxt                = 1'b0;
         end
      end
      if (w_wr_addr) begin
         if (!r_w) begin
            w_t_nxt[13:8] = reg_din[5:0];
            w_t_nxt[14]   = 1'b0;
            w_w_nxt       = 1'b1;
         end else begin
            w_t_nxt[7:0]  = reg_din;
            w_w_nxt       = 1'b0;
         end
      end
      if (w_rd_status)
         w_w_nxt = 1'b0;
   end

   // Copies are applied after increments so they win on shared fields.
   always_comb begin
      w_v_nxt = r_v;
      if (render_en) begin
         if (w_do_cx) begin
            w_v_nxt[NT_X]          = w_v_cx[NT_X];
            w_v_nxt[CX_MSB:CX_LSB] = w_v_cx[CX_MSB:CX_LSB];
         end
         if (w_do_y) begin
            w_v_nxt[FY_MSB:NT_Y]   = w_v_y[FY_MSB:NT_Y];
            w_v_nxt[CY_MSB:CY_LSB] = w_v_y[CY_MSB:CY_LSB];
         end
         if (copy_h) begin
            w_v_nxt[NT_X]          = r_t[NT_X];
            w_v_nxt[CX_MSB:CX_LSB] = r_t[CX_MSB:CX_LSB];
         end
         if (copy_v) begin
            w_v_nxt[FY_MSB:NT_Y]   = r_t[FY_MSB:NT_Y];
            w_v_nxt[CY_MSB:CY_LSB] = r_t[CY_MSB:CY_LSB];
         end
      end else if (data_inc) begin
         w_v_nxt = r_v + (inc32 ? 15'd32 : 15'd1);
      end
      if (w_wr_addr && r_w)
         w_v_nxt = {r_t[14:8], reg_din};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_v <= '0;
         r_t <= '0;
         r_x <= '0;
         r_w <= 1'b0;
      end else begin
         r_v <= w_v_nxt;
         r_t <= w_t_nxt;
         r_x <= w_x_nxt;
         r_w <= w_w_nxt;
      end
   end

   always_comb begin
      if (fetch_attr)
         vaddr = NT_BASE | {4'b0, AT_OFFSET} | {2'b0, r_v[NT_Y:NT_X], 10'b0}
               | {8'b0, r_v[9:7], 3'b0} | {11'b0, r_v[4:2]};
      else if (fetch_nt)
         vaddr = NT_BASE | {2'b0, r_v[11:0]};
      else
         vaddr = r_v[13:0];
   end

   assign attr_o = 2'(data_i >> {r_v[6], r_v[1], 1'b0});
   assign fine_x = r_x;
   assign fine_y = r_v[FY_MSB:FY_LSB];

endmodule

// File: tb/tb_scroll_addr.sv
// tb/tb_scroll_addr.sv - directed scoreboard bench for scroll_addr
module tb_scroll_addr;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        reg_wr, reg_rd, data_inc, inc32, render_en;
   logic        inc_cx, inc_y, copy_h, copy_v, fetch_nt, fetch_attr;
   logic [2:0]  reg_sel;
   logic [7:0]  reg_din, data_i;
   logic [13:0] vaddr;
   logic [2:0]  fine_x, fine_y;
   logic [1:0]  attr_o;

   int n_cmp = 0;
   int n_mis = 0;

   typedef enum int {K_V, K_T, K_X, K_W, K_VADDR, K_FX, K_FY, K_ATTR} kind_t;
   typedef struct {
      string       tag;
      kind_t       kind;
      logic [15:0] val;
   } exp_t;
   exp_t sb[$];

   scroll_addr dut (
      .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .reg_rd(reg_rd),
      .reg_sel(reg_sel), .reg_din(reg_din), .data_inc(data_inc), .inc32(inc32),
      .render_en(render_en), .inc_cx(inc_cx), .inc_y(inc_y), .copy_h(copy_h),
      .copy_v(copy_v), .fetch_nt(fetch_nt), .fetch_attr(fetch_attr), .data_i(data_i),
      .vaddr(vaddr), .fine_x(fine_x), .fine_y(fine_y), .attr_o(attr_o)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] observe(input kind_t k);
      case (k)
         K_V:     return {1'b0, dut.r_v};
         K_T:     return {1'b0, dut.r_t};
         K_X:     return {13'b0, dut.r_x};
         K_W:     return {15'b0, dut.r_w};
         K_VADDR: return {2'b0, vaddr};
         K_FX:    return {13'b0, fine_x};
         K_FY:    return {13'b0, fine_y};
         default: return {14'b0, attr_o};
      endcase
   endfunction

   task automatic push(input string tag, input kind_t k, input logic [15:0] val);
      exp_t e;
      e.tag = tag; e.kind = k; e.val = val;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      logic [15:0] obs;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         obs = observe(e.kind);
         n_cmp++;
         assert (obs === e.val) else begin
            n_mis++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] sel, input logic [7:0] d);
      reg_wr = 1'b1; reg_sel = sel; reg_din = d;
      tick();
      reg_wr = 1'b0;
   endtask

   task automatic rd(input logic [2:0] sel);
      reg_rd = 1'b1; reg_sel = sel;
      tick();
      reg_rd = 1'b0;
   endtask

   // Loads t field by field through $2000/$2005, then copies all of t into v.
   task automatic set_v(input logic [14:0] val);
      wr(3'd0, {6'b0, val[11:10]});
      wr(3'd5, {val[4:0], 3'b0});
      wr(3'd5, {val[9:5], val[14:12]});
      render_en = 1'b1; copy_h = 1'b1; copy_v = 1'b1;
      tick();
      render_en = 1'b0; copy_h = 1'b0; copy_v = 1'b0;
   endtask

   task automatic strobe_render(input logic cx, input logic y);
      render_en = 1'b1; inc_cx = cx; inc_y = y;
      tick();
      render_en = 1'b0; inc_cx = 1'b0; inc_y = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      {reg_wr, reg_rd, data_inc, inc32, render_en} = '0;
      {inc_cx, inc_y, copy_h, copy_v, fetch_nt, fetch_attr} = '0;
      reg_sel = '0; reg_din = '0; data_i = 8'hA6;
      tick(); tick();
      rst_n = 1'b1;
      push("rst_v", K_V, 16'h0);
      push("rst_t", K_T, 16'h0);
      push("rst_x", K_X, 16'h0);
      push("rst_w", K_W, 16'h0);
      push("rst_vaddr", K_VADDR, 16'h0);
      push("rst_fine_x", K_FX, 16'h0);
      push("rst_fine_y", K_FY, 16'h0);
      push("rst_attr", K_ATTR, 16'h2);
      drain();

      wr(3'd5, 8'h7D);
      push("scroll1_w", K_W, 16'h1);
      push("scroll1_x", K_X, 16'h5);
      drain();
      wr(3'd5, 8'h5E);
      push("scroll2_t", K_T, 16'h616F);
      push("scroll2_x", K_X, 16'h5);
      push("scroll2_w", K_W, 16'h0);
      push("scroll2_fine_x", K_FX, 16'h5);
      drain();

      wr(3'd6, 8'h21);
      push("addr1_w", K_W, 16'h1);
      drain();
      wr(3'd6, 8'h08);
      push("addr2_v", K_V, 16'h2108);
      push("addr2_vaddr", K_VADDR, 16'h2108);
      push("addr2_w", K_W, 16'h0);
      drain();
      data_inc = 1'b1; inc32 = 1'b0; tick(); data_inc = 1'b0;
      push("inc1_v", K_V, 16'h2109);
      drain();
      data_inc = 1'b1; inc32 = 1'b1; tick(); data_inc = 1'b0; inc32 = 1'b0;
      push("inc32_v", K_V, 16'h2129);
      drain();

      set_v(15'h001F);
      push("setv_001f", K_V, 16'h001F);
      drain();
      strobe_render(1'b1, 1'b0);
      push("inc_cx_wrap", K_V, 16'h0400);
      drain();
      inc_cx = 1'b1; tick(); inc_cx = 1'b0;
      push("inc_cx_norender", K_V, 16'h0400);
      drain();

      set_v(15'h73A0);
      strobe_render(1'b0, 1'b1);
      push("inc_y_29", K_V, 16'h0800);
      drain();
      set_v(15'h73E0);
      strobe_render(1'b0, 1'b1);
      push("inc_y_31", K_V, 16'h0000);
      drain();
      set_v(15'h0000);
      strobe_render(1'b0, 1'b1);
      push("inc_y_fine", K_V, 16'h1000);
      push("inc_y_fine_y", K_FY, 16'h1);
      drain();

      wr(3'd6, 8'h21);
      wr(3'd6, 8'h08);
      fetch_nt = 1'b1; #1;
      push("fetch_nt", K_VADDR, 16'h2108);
      drain();
      fetch_attr = 1'b1; #1;
      push("fetch_attr_prio", K_VADDR, 16'h23D2);
      drain();
      fetch_nt = 1'b0; fetch_attr = 1'b0;
      wr(3'd6, 8'h00);
      wr(3'd6, 8'h42);
      data_i = 8'hE4; #1;
      push("attr_q3", K_ATTR, 16'h3);
      drain();

      wr(3'd5, 8'h13);
      push("mid_w1", K_W, 16'h1);
      push("mid_x1", K_X, 16'h3);
      drain();
      rd(3'd2);
      push("status_clr_w", K_W, 16'h0);
      drain();
      wr(3'd5, 8'hFE);
      push("rewrite_x", K_X, 16'h6);
      push("rewrite_w", K_W, 16'h1);
      drain();

      rd(3'd2);
      wr(3'd6, 8'h15);
      reg_wr = 1'b1; reg_sel = 3'd6; reg_din = 8'h77;
      render_en = 1'b1; inc_cx = 1'b1; inc_y = 1'b1;
      tick();
      reg_wr = 1'b0; render_en = 1'b0; inc_cx = 1'b0; inc_y = 1'b0;
      push("addr2_overrides", K_V, 16'h1577);
      drain();

      render_en = 1'b1; data_inc = 1'b1; tick();
      render_en = 1'b0; data_inc = 1'b0;
`ifdef SCROLL_RENDER_GLITCH_EN
      push("data_inc_render", K_V, 16'h2578);
`else
      push("data_inc_render", K_V, 16'h1577);
`endif
      drain();

      rst_n = 1'b0;
      #2;
      push("async_rst_v", K_V, 16'h0);
      push("async_rst_t", K_T, 16'h0);
      push("async_rst_x", K_X, 16'h0);
      push("async_rst_w", K_W, 16'h0);
      drain();
      rst_n = 1'b1;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
